mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one memory port between the core's instruction bus and data bus.
- Sits between the core's ibus/dbus request outputs and the memory/cache port.
- Picks one requester, latches its request and drives it downstream, then routes the response back.
- Only one transaction is outstanding at a time; data side has priority, with starvation protection for the instruction side.

Parameters:
- DATA_FIRST, 1: 1 = data bus wins ties; 0 = instruction bus wins ties.
- STARVE_LIMIT, 4: consecutive tie wins by the priority side before the other side is forced a grant; range 1..15.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- i_valid  in  1  instruction fetch request
- i_addr  in  32  fetch address
- i_addr_ok  out  1  fetch request accepted downstream (pulse)
- i_data_ok  out  1  fetch data returned (pulse)
- i_rdata  out  32  fetch data, valid with i_data_ok
- d_valid  in  1  data request
- d_addr  in  32  data address
- d_strobe  in  4  byte write enables; 0 = read
- d_wdata  in  32  write data
- d_addr_ok  out  1  data request accepted downstream (pulse)
- d_data_ok  out  1  data response (pulse); also signals write completion
- d_rdata  out  32  read data, valid with d_data_ok
- m_valid  out  1  downstream request valid
- m_addr  out  32  latched address
- m_strobe  out  4  latched strobe; always 0 for fetches
- m_wdata  out  32  latched write data
- m_ready  in  1  downstream accepts request this cycle
- m_rvalid  in  1  downstream response valid
- m_rdata  in  32  downstream response data

Behaviour:
- Single clock domain. Reset is synchronous and active-high: on posedge clk with reset=1, the block enters IDLE.
- Reset values: all outputs 0, starvation counter 0, latched request 0, owner = none.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - If neither valid is set, stay in IDLE.
  - If only one valid is set, grant that side.
  - If both are valid, grant the tie-winner by DATA_FIRST, unless starve_cnt == STARVE_LIMIT; then grant the other side and clear starve_cnt.
  - On a grant: latch addr/strobe/wdata from the granted side, record owner, go to ISSUE.
- IDLE grant has no upstream-visible output that cycle.
- Starvation counter (4-bit), updated only on IDLE grants:
  - Increment when both sides are valid and the tie-winner is granted.
  - Clear when the losing side is not valid.
  - Saturates at STARVE_LIMIT.
- ISSUE:
  - m_valid=1; m_addr/m_strobe/m_wdata come from the latch and stay stable until accepted.
  - On m_ready=1: pulse the owner's addr_ok combinationally in the same cycle, go to WAIT.
  - Otherwise hold the state and all m_* outputs.
- WAIT:
  - m_valid=0.
  - On m_rvalid=1: owner's data_ok=1 in the same cycle and owner's rdata=m_rdata (combinational pass-through), go to IDLE.
  - m_rvalid in IDLE or ISSUE is ignored and never forwarded.
- The non-owner's addr_ok and data_ok are always 0. rdata outputs are 0 whenever the matching data_ok is 0.
- Minimum latency:
  - Request at IDLE cycle t: m_valid at t+1, addr_ok at t+1 if m_ready.
  - data_ok no earlier than t+2.
  - One IDLE bubble between back-to-back transactions; next grant at the earliest in the cycle after data_ok.
- Requester inputs are sampled only in IDLE. A requester dropping valid or changing addr after grant does not affect the latched transaction, which completes normally.
- Requesters hold valid until their addr_ok. A requester still valid after data_ok is treated as a new request.
- Reset mid-transaction (ISSUE or WAIT): return to IDLE, drop the transaction, no addr_ok/data_ok emitted. A late m_rvalid after reset is ignored.
- Write transactions (d_strobe≠0) complete through WAIT like reads. d_rdata on completion equals m_rdata; the requester ignores it.
- Width rules: m_strobe is forced to 4'b0000 when the owner is the instruction side.

Test Plan:
- Fetch only, m_ready=1 at first ISSUE, m_rvalid two cycles later with 0xDEADBEEF, i_valid/i_addr=0x1000 held -> m_addr=0x1000 and m_strobe=0 in ISSUE; i_addr_ok one cycle after the request; i_data_ok=1 with i_rdata=0xDEADBEEF; d_* outputs stay 0.
- d_valid and i_valid both held high continuously, DATA_FIRST=1, STARVE_LIMIT=4, immediate ready/rvalid -> grant order D,D,D,D,I,D,D,D,D,I.
- Data write, d_addr=0x2004, d_strobe=4'b0011, d_wdata=0x12345678, m_ready held 0 for 3 cycles -> m_* outputs stable across all 4 ISSUE cycles; d_addr_ok only in the cycle m_ready=1; d_data_ok on m_rvalid.
- Spurious m_rvalid=1 in IDLE and in ISSUE -> no data_ok pulses, FSM unchanged.
- reset=1 asserted in WAIT, then m_rvalid=1 the cycle after reset is released -> no data_ok; FSM in IDLE; all outputs 0 during reset.
- i_valid deasserted one cycle after grant (before m_ready) -> transaction still issued with the latched address; i_addr_ok and i_data_ok still pulse.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one memory port between the core's instruction bus (i_*) and data
// bus (d_*). One requester is granted in IDLE, its request is latched and
// driven downstream (ISSUE), and the single downstream response is routed
// back to that requester (WAIT). Only one transaction is outstanding.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   i_valid, i_addr     instruction fetch request
//   i_addr_ok           fetch accepted downstream (1-cycle pulse)
//   i_data_ok, i_rdata  fetch data return (pulse), data valid with the pulse
//   d_valid, d_addr,
//   d_strobe, d_wdata   data request; d_strobe == 0 means read
//   d_addr_ok           data request accepted downstream (pulse)
//   d_data_ok, d_rdata  data response / write completion (pulse)
//   m_valid, m_addr,
//   m_strobe, m_wdata   downstream request, held from the latch
//   m_ready             downstream accepts the request this cycle
//   m_rvalid, m_rdata   downstream response
//   fsm_state           current FSM state (debug visibility)
//
// Handshake: a downstream request transfers in a cycle where
// m_valid && m_ready; m_valid rises only from a registered grant and
// m_addr/m_strobe/m_wdata are held from the latch until that transfer. A
// response is a single m_rvalid cycle and is consumed only in WAIT; the
// upstream addr_ok/data_ok pulses are combinational echoes of those events
// and go only to the owner of the transaction.
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter logic DATA_FIRST   = 1'b1,
    parameter int   STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_valid,
    input  logic [31:0] i_addr,
    output logic        i_addr_ok,
    output logic        i_data_ok,
    output logic [31:0] i_rdata,
    input  logic        d_valid,
    input  logic [31:0] d_addr,
    input  logic [3:0]  d_strobe,
    input  logic [31:0] d_wdata,
    output logic        d_addr_ok,
    output logic        d_data_ok,
    output logic [31:0] d_rdata,
    output logic        m_valid,
    output logic [31:0] m_addr,
    output logic [3:0]  m_strobe,
    output logic [31:0] m_wdata,
    input  logic        m_ready,
    input  logic        m_rvalid,
    input  logic [31:0] m_rdata,
    output logic [1:0]  fsm_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t      state;
    owner_t      owner;
    logic [3:0]  starve_cnt;
    logic [31:0] lat_addr;
    logic [3:0]  lat_strobe;
    logic [31:0] lat_wdata;
    logic        m_valid_r;

    // Tie-break in terms of "winner" (priority side) and "loser" so that
    // DATA_FIRST only swaps which bus plays which role.
    logic       win_valid;
    logic       lose_valid;
    logic       grant_win;
    logic       grant_lose;
    logic       grant_i;
    logic       grant_d;
    logic [3:0] starve_next;

    always_comb begin
        win_valid   = DATA_FIRST ? d_valid : i_valid;
        lose_valid  = DATA_FIRST ? i_valid : d_valid;
        grant_win   = 1'b0;
        grant_lose  = 1'b0;
        starve_next = starve_cnt;
        if (win_valid && lose_valid) begin
            if (starve_cnt == LIMIT) begin
                // The losing side has been passed over enough times in a row.
                grant_lose  = 1'b1;
                starve_next = 4'd0;
            end else begin
                grant_win   = 1'b1;
                starve_next = (starve_cnt >= LIMIT) ? LIMIT : starve_cnt + 4'd1;
            end
        end else if (win_valid) begin
            // Nobody was waiting behind the winner, so the streak is broken.
            grant_win   = 1'b1;
            starve_next = 4'd0;
        end else if (lose_valid) begin
            grant_lose  = 1'b1;
        end
        grant_d = DATA_FIRST ? grant_win : grant_lose;
        grant_i = DATA_FIRST ? grant_lose : grant_win;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            owner      <= OWN_NONE;
            starve_cnt <= 4'd0;
            lat_addr   <= 32'd0;
            lat_strobe <= 4'd0;
            lat_wdata  <= 32'd0;
            m_valid_r  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_i || grant_d) begin
                        starve_cnt <= starve_next;
                        owner      <= grant_d ? OWN_D : OWN_I;
                        lat_addr   <= grant_d ? d_addr : i_addr;
                        lat_strobe <= grant_d ? d_strobe : 4'd0;
                        lat_wdata  <= grant_d ? d_wdata : 32'd0;
                        m_valid_r  <= 1'b1;
                        state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (m_ready) begin
                        m_valid_r <= 1'b0;
                        state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (m_rvalid) begin
                        owner <= OWN_NONE;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    owner     <= OWN_NONE;
                    m_valid_r <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

    // Upstream pulses are suppressed while reset is held so an aborted
    // transaction never reports acceptance or completion.
    logic accept;
    logic respond;

    assign accept  = !reset && (state == ST_ISSUE) && m_ready;
    assign respond = !reset && (state == ST_WAIT) && m_rvalid;

    assign i_addr_ok = accept  && (owner == OWN_I);
    assign d_addr_ok = accept  && (owner == OWN_D);
    assign i_data_ok = respond && (owner == OWN_I);
    assign d_data_ok = respond && (owner == OWN_D);
    assign i_rdata   = i_data_ok ? m_rdata : 32'd0;
    assign d_rdata   = d_data_ok ? m_rdata : 32'd0;

    assign m_valid   = m_valid_r;
    assign m_addr    = lat_addr;
    assign m_strobe  = (owner == OWN_I) ? 4'd0 : lat_strobe;
    assign m_wdata   = lat_wdata;
    assign fsm_state = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter (DATA_FIRST=1, STARVE_LIMIT=4).
// The stimulus process drives inputs one cycle at a time and pushes the
// expected downstream request / upstream response of every transaction into
// queues; it also posts per-cycle expected FSM state and pulse flags. A
// separate monitor, sampling on the falling edge, pops and compares whenever
// the DUT pulses addr_ok or data_ok, checks the posted per-cycle
// expectations, request stability while m_valid is held, zeroed outputs
// under reset, and prints the final report.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int IW = 69;   // {side_d, addr, strobe, wdata}
  localparam int RW = 33;   // {side_d, rdata}
  localparam int CW = 160;  // comparison width

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  // flag vector: {m_valid, i_addr_ok, i_data_ok, d_addr_ok, d_data_ok}
  localparam logic [4:0] F_NONE = 5'b00000;
  localparam logic [4:0] F_MV   = 5'b10000;
  localparam logic [4:0] F_IA   = 5'b01000;
  localparam logic [4:0] F_ID   = 5'b00100;
  localparam logic [4:0] F_DA   = 5'b00010;
  localparam logic [4:0] F_DD   = 5'b00001;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  always #5 clk = ~clk;

  logic        i_valid, i_addr_ok, i_data_ok;
  logic [31:0] i_addr, i_rdata;
  logic        d_valid, d_addr_ok, d_data_ok;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_strobe;
  logic        m_valid, m_ready, m_rvalid;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_strobe;
  logic [1:0]  fsm_state;

  mem_port_arbiter #(
    .DATA_FIRST   (1'b1),
    .STARVE_LIMIT (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .i_valid   (i_valid),
    .i_addr    (i_addr),
    .i_addr_ok (i_addr_ok),
    .i_data_ok (i_data_ok),
    .i_rdata   (i_rdata),
    .d_valid   (d_valid),
    .d_addr    (d_addr),
    .d_strobe  (d_strobe),
    .d_wdata   (d_wdata),
    .d_addr_ok (d_addr_ok),
    .d_data_ok (d_data_ok),
    .d_rdata   (d_rdata),
    .m_valid   (m_valid),
    .m_addr    (m_addr),
    .m_strobe  (m_strobe),
    .m_wdata   (m_wdata),
    .m_ready   (m_ready),
    .m_rvalid  (m_rvalid),
    .m_rdata   (m_rdata),
    .fsm_state (fsm_state)
  );

  logic rst_q = 1'b1;
  always @(posedge clk) rst_q <= reset;

  // ---------------- scoreboard state ----------------
  logic [IW-1:0] exp_issue_q[$];
  logic [RW-1:0] exp_resp_q[$];

  int          checks = 0;
  int          passes = 0;
  int          probe_id = 0;
  int          seen_id = 0;
  logic [1:0]  probe_state = 2'd0;
  logic [4:0]  probe_flags = 5'd0;
  logic        done = 1'b0;
  logic        hold_act = 1'b0;
  logic [67:0] held = '0;
  logic [IW-1:0] e_i;
  logic [RW-1:0] e_r;

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic probe(input logic [1:0] s, input logic [4:0] f);
    probe_state = s;
    probe_flags = f;
    probe_id++;
  endtask

  task automatic push_issue(input logic side_d, input logic [31:0] a,
                            input logic [3:0] s, input logic [31:0] w);
    exp_issue_q.push_back({side_d, a, s, w});
  endtask

  task automatic push_resp(input logic side_d, input logic [31:0] r);
    exp_resp_q.push_back({side_d, r});
  endtask

  // ---------------- monitor / checker ----------------
  task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (done) begin
        chk("issue_queue_drained", CW'(exp_issue_q.size()), '0);
        chk("resp_queue_drained", CW'(exp_resp_q.size()), '0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
      end
      if (rst_q)
        chk("reset_outputs_zero",
            CW'({i_addr_ok, i_data_ok, i_rdata, d_addr_ok, d_data_ok, d_rdata,
                 m_valid, m_addr, m_strobe, m_wdata, fsm_state}), '0);
      if (i_addr_ok || d_addr_ok) begin
        chk("addr_ok_exclusive", CW'(i_addr_ok & d_addr_ok), '0);
        if (exp_issue_q.size() == 0) begin
          chk("unexpected_addr_ok", CW'(1), '0);
        end else begin
          e_i = exp_issue_q.pop_front();
          chk("issue_request", CW'({d_addr_ok, m_addr, m_strobe, m_wdata}), CW'(e_i));
          chk("issue_m_valid", CW'(m_valid), CW'(1));
        end
      end
      if (i_data_ok || d_data_ok) begin
        chk("data_ok_exclusive", CW'(i_data_ok & d_data_ok), '0);
        if (exp_resp_q.size() == 0) begin
          chk("unexpected_data_ok", CW'(1), '0);
        end else begin
          e_r = exp_resp_q.pop_front();
          chk("response", CW'({d_data_ok, d_data_ok ? d_rdata : i_rdata}), CW'(e_r));
        end
      end
      if (!i_data_ok) chk("i_rdata_zero", CW'(i_rdata), '0);
      if (!d_data_ok) chk("d_rdata_zero", CW'(d_rdata), '0);
      if (m_valid && hold_act)
        chk("m_request_stable", CW'({m_addr, m_strobe, m_wdata}), CW'(held));
      hold_act = m_valid && !(i_addr_ok || d_addr_ok);
      held     = {m_addr, m_strobe, m_wdata};
      if (probe_id != seen_id) begin
        seen_id = probe_id;
        chk($sformatf("cycle_probe_%0d", probe_id),
            CW'({fsm_state, m_valid, i_addr_ok, i_data_ok, d_addr_ok, d_data_ok}),
            CW'({probe_state, probe_flags}));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stimulus
    string order;
    logic  sd;
    order    = "DDDDIDDDDI";
    i_valid  = 1'b0; i_addr  = 32'd0;
    d_valid  = 1'b0; d_addr  = 32'd0; d_strobe = 4'd0; d_wdata = 32'd0;
    m_ready  = 1'b0; m_rvalid = 1'b0; m_rdata = 32'd0;
    reset    = 1'b1;
    step(); step(); step();
    probe(S_IDLE, F_NONE);
    reset = 1'b0;

    // Fetch only: request, accept next cycle, data two cycles after request.
    step();
    i_valid = 1'b1; i_addr = 32'h0000_1000; m_ready = 1'b1;
    push_issue(1'b0, 32'h0000_1000, 4'd0, 32'd0);
    push_resp(1'b0, 32'hDEAD_BEEF);
    probe(S_IDLE, F_NONE);
    step();
    probe(S_ISSUE, F_MV | F_IA);
    step();
    i_valid = 1'b0; m_ready = 1'b0; m_rvalid = 1'b1; m_rdata = 32'hDEAD_BEEF;
    probe(S_WAIT, F_ID);
    step();
    m_rvalid = 1'b0;
    probe(S_IDLE, F_NONE);

    // Data write with m_ready low for three ISSUE cycles; requester inputs
    // and a spurious m_rvalid change mid-ISSUE must not disturb anything.
    step();
    d_valid = 1'b1; d_addr = 32'h0000_2004; d_strobe = 4'b0011; d_wdata = 32'h1234_5678;
    push_issue(1'b1, 32'h0000_2004, 4'b0011, 32'h1234_5678);
    push_resp(1'b1, 32'hCAFE_0001);
    probe(S_IDLE, F_NONE);
    step();
    probe(S_ISSUE, F_MV);
    step();
    d_addr = 32'hFFFF_FFF0; d_wdata = 32'h0; m_rvalid = 1'b1; m_rdata = 32'h5555_AAAA;
    probe(S_ISSUE, F_MV);
    step();
    m_rvalid = 1'b0;
    probe(S_ISSUE, F_MV);
    step();
    m_ready = 1'b1;
    probe(S_ISSUE, F_MV | F_DA);
    step();
    d_valid = 1'b0; m_ready = 1'b0;
    probe(S_WAIT, F_NONE);
    step();
    m_rvalid = 1'b1; m_rdata = 32'hCAFE_0001;
    probe(S_WAIT, F_DD);
    step();
    m_rvalid = 1'b0;
    probe(S_IDLE, F_NONE);

    // Spurious m_rvalid in IDLE.
    step();
    m_rvalid = 1'b1; m_rdata = 32'h1111_2222;
    probe(S_IDLE, F_NONE);
    step();
    m_rvalid = 1'b0;
    probe(S_IDLE, F_NONE);

    // Reset while waiting for the response; late m_rvalid afterwards.
    step();
    i_valid = 1'b1; i_addr = 32'h0000_3000; m_ready = 1'b1;
    push_issue(1'b0, 32'h0000_3000, 4'd0, 32'd0);
    probe(S_IDLE, F_NONE);
    step();
    probe(S_ISSUE, F_MV | F_IA);
    step();
    i_valid = 1'b0; m_ready = 1'b0;
    probe(S_WAIT, F_NONE);
    reset = 1'b1;
    step();
    probe(S_IDLE, F_NONE);
    step();
    reset = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h0BAD_0BAD;
    probe(S_IDLE, F_NONE);
    step();
    probe(S_IDLE, F_NONE);
    step();
    m_rvalid = 1'b0;
    probe(S_IDLE, F_NONE);

    // Fetch whose requester drops valid and changes address right after grant.
    step();
    i_valid = 1'b1; i_addr = 32'h0000_4000;
    push_issue(1'b0, 32'h0000_4000, 4'd0, 32'd0);
    push_resp(1'b0, 32'h0BAD_F00D);
    probe(S_IDLE, F_NONE);
    step();
    i_valid = 1'b0; i_addr = 32'h0000_5555;
    probe(S_ISSUE, F_MV);
    step();
    m_ready = 1'b1;
    probe(S_ISSUE, F_MV | F_IA);
    step();
    m_ready = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h0BAD_F00D;
    probe(S_WAIT, F_ID);
    step();
    m_rvalid = 1'b0;
    probe(S_IDLE, F_NONE);

    // Both sides continuously valid, immediate ready/response:
    // data wins four ties, then the fetch side is forced through.
    step();
    i_valid = 1'b1; i_addr = 32'h0000_0100;
    d_valid = 1'b1; d_addr = 32'h0000_0200; d_strobe = 4'hF; d_wdata = 32'h0000_0077;
    m_ready = 1'b1; m_rvalid = 1'b1; m_rdata = 32'hA5A5_5A5A;
    for (int k = 0; k < 10; k++) begin
      sd = (order[k] == "D");
      if (sd) push_issue(1'b1, 32'h0000_0200, 4'hF, 32'h0000_0077);
      else    push_issue(1'b0, 32'h0000_0100, 4'h0, 32'h0000_0000);
      push_resp(sd, 32'hA5A5_5A5A);
    end
    for (int k = 0; k < 10; k++) begin
      sd = (order[k] == "D");
      probe(S_IDLE, F_NONE);
      step();
      probe(S_ISSUE, F_MV | (sd ? F_DA : F_IA));
      step();
      probe(S_WAIT, sd ? F_DD : F_ID);
      step();
    end
    i_valid = 1'b0; d_valid = 1'b0; m_ready = 1'b0; m_rvalid = 1'b0;
    probe(S_IDLE, F_NONE);
    step();
    probe(S_IDLE, F_NONE);
    step();
    done = 1'b1;
  end

endmodule
